// File: rtl/adc_pkg.sv
// Shared types and default constants for the serial ADC read controller.
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    QUIET = 2'd3
  } adc_state_e;

  localparam int ADC_CLK_DIV    = 25;
  localparam int ADC_FRAME_BITS = 16;
  localparam int ADC_DATA_W     = 12;

endpackage

// File: rtl/adc_serial_ctrl_sclk_div.sv
// Half-period tick generator for the ADC serial clock: one-cycle half_tick
// every CLK_DIV cycles while enabled, count cleared on frame start.
module sclk_div #(
  parameter int CLK_DIV = 25
) (
  input  logic s_clk,
  input  logic s_rst_n,
  input  logic clr,
  input  logic en,
  output logic half_tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign half_tick = en && !clr && (cnt_q == CNT_MAX);

endmodule

// File: rtl/adc_serial_ctrl.sv
// Serial ADC read controller: on an adc_en pulse, runs one chip-select frame,
// captures adc_dout on each SCLK rise and returns the low DATA_W bits.
module adc_serial_ctrl
  import adc_pkg::*;
#(
  parameter int CLK_DIV    = ADC_CLK_DIV,
  parameter int FRAME_BITS = ADC_FRAME_BITS,
  parameter int DATA_W     = ADC_DATA_W
) (
  input  logic              s_clk,
  input  logic              s_rst_n,
  input  logic              adc_en,
  input  logic              adc_dout,
  output logic              adc_cs_n,
  output logic              adc_sclk,
  output logic [DATA_W-1:0] adc_data,
  output logic              adc_vld,
  output logic              busy,
  output adc_state_e        state_dbg
);

  localparam int BIT_W = $clog2(FRAME_BITS + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS - 1);

  adc_state_e              state_q, state_d;
  logic                    cs_n_q, cs_n_d;
  logic                    sclk_q, sclk_d;
  logic [DATA_W-1:0]       data_q, data_d;
  logic                    vld_q, vld_d;
  logic                    busy_q, busy_d;
  logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0]   sh_q, sh_d;
  logic [FRAME_BITS-1:0]   sh_next;

  logic div_clr;
  logic div_en;
  logic half_tick;

  assign div_clr = (state_q == IDLE) && adc_en;
  assign div_en  = (state_q != IDLE);

  sclk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_div (
    .s_clk     (s_clk),
    .s_rst_n   (s_rst_n),
    .clr       (div_clr),
    .en        (div_en),
    .half_tick (half_tick)
  );

  // Sample taken on the same edge that registers SCLK high: mid-bit for an
  // ADC that changes its output on falling edges.
  assign sh_next = FRAME_BITS'({sh_q, adc_dout});

  always_comb begin
    state_d   = state_q;
    cs_n_d    = cs_n_q;
    sclk_d    = sclk_q;
    data_d    = data_q;
    vld_d     = 1'b0;
    busy_d    = busy_q;
    bit_cnt_d = bit_cnt_q;
    sh_d      = sh_q;
    case (state_q)
      IDLE: begin
        if (adc_en) begin
          state_d   = SETUP;
          cs_n_d    = 1'b0;
          busy_d    = 1'b1;
          bit_cnt_d = '0;
        end
      end
      SETUP: begin
        if (half_tick) begin
          state_d = SHIFT;
          sclk_d  = 1'b1;
          sh_d    = sh_next;
        end
      end
      SHIFT: begin
        if (half_tick) begin
          if (sclk_q) begin
            sclk_d = 1'b0;
          end else if (bit_cnt_q == LAST_BIT) begin
            state_d = QUIET;
            cs_n_d  = 1'b1;
            vld_d   = 1'b1;
            data_d  = sh_q[DATA_W-1:0];
          end else begin
            sclk_d    = 1'b1;
            bit_cnt_d = bit_cnt_q + 1'b1;
            sh_d      = sh_next;
          end
        end
      end
      QUIET: begin
        if (half_tick) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q   <= IDLE;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b0;
      data_q    <= '0;
      vld_q     <= 1'b0;
      busy_q    <= 1'b0;
      bit_cnt_q <= '0;
      sh_q      <= '0;
    end else begin
      state_q   <= state_d;
      cs_n_q    <= cs_n_d;
      sclk_q    <= sclk_d;
      data_q    <= data_d;
      vld_q     <= vld_d;
      busy_q    <= busy_d;
      bit_cnt_q <= bit_cnt_d;
      sh_q      <= sh_d;
    end
  end

  assign adc_cs_n  = cs_n_q;
  assign adc_sclk  = sclk_q;
  assign adc_data  = data_q;
  assign adc_vld   = vld_q;
  assign busy      = busy_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_adc_serial_ctrl.sv
// Bench for adc_serial_ctrl with CLK_DIV=2, FRAME_BITS=16, DATA_W=12 and a
// falling-edge-shifting ADC model; results checked through an expected queue.
module tb_adc_serial_ctrl;
  import adc_pkg::*;

  localparam int DIV = 2;
  localparam int FB  = 16;
  localparam int DW  = 12;

  // Clock / reset
  logic s_clk = 1'b0;
  logic s_rst_n = 1'b0;
  always #5 s_clk = ~s_clk;

  logic          adc_en = 1'b0;
  logic          adc_dout = 1'b0;
  logic          adc_cs_n;
  logic          adc_sclk;
  logic [DW-1:0] adc_data;
  logic          adc_vld;
  logic          busy;
  adc_state_e    state_dbg;

  adc_serial_ctrl #(
    .CLK_DIV    (DIV),
    .FRAME_BITS (FB),
    .DATA_W     (DW)
  ) dut (
    .s_clk     (s_clk),
    .s_rst_n   (s_rst_n),
    .adc_en    (adc_en),
    .adc_dout  (adc_dout),
    .adc_cs_n  (adc_cs_n),
    .adc_sclk  (adc_sclk),
    .adc_data  (adc_data),
    .adc_vld   (adc_vld),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_cnt  = 0;
  int vld_cnt  = 0;

  always @(posedge s_clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ADC model: MSB presented when chip select falls, next bit on each SCLK fall
  logic [15:0] frame_q[$];
  logic [15:0] cur_frame = '0;
  logic [15:0] shifted;
  int          bit_idx = 0;

  always @(negedge adc_cs_n) begin
    cur_frame = (frame_q.size() > 0) ? frame_q.pop_front() : 16'h0000;
    bit_idx   = 0;
    adc_dout  = cur_frame[15];
  end

  always @(negedge adc_sclk) begin
    if (!adc_cs_n) begin
      bit_idx++;
      shifted  = cur_frame << bit_idx;
      adc_dout = shifted[15];
    end
  end

  // Scoreboard
  logic [DW-1:0] exp_q[$];
  int            exp_cyc_q[$];

  always @(negedge s_clk) begin
    if (adc_vld) begin
      vld_cnt++;
      if (exp_q.size() == 0) begin
        check("vld_unexpected", 32'd1, 32'd0);
      end else begin
        check("vld_data", 32'(adc_data), 32'(exp_q.pop_front()));
        check("vld_cycle", 32'(cyc_cnt), 32'(exp_cyc_q.pop_front()));
      end
    end
  end

  // Driver: called just after a rising edge; rel is the adc_vld cycle
  // counted from the cycle adc_en is first driven in the next window.
  task automatic issue_frame(input logic [15:0] frame, input logic [DW-1:0] exp_data, input int rel);
    frame_q.push_back(frame);
    exp_q.push_back(exp_data);
    exp_cyc_q.push_back(cyc_cnt + 1 + rel);
  endtask

  int cs_falls[$];
  int cs_rises[$];
  int busy_falls[$];
  int sclk_rises[$];

  task automatic run_window(input int len, input int p0, input int p1, input int p2, input int p3);
    logic pcs, psclk, pbusy;
    cs_falls.delete();
    cs_rises.delete();
    busy_falls.delete();
    sclk_rises.delete();
    pcs   = adc_cs_n;
    psclk = adc_sclk;
    pbusy = busy;
    for (int c = 0; c < len; c++) begin
      @(posedge s_clk);
      #1;
      adc_en = (c == p0) || (c == p1) || (c == p2) || (c == p3);
      @(negedge s_clk);
      if (pcs && !adc_cs_n) cs_falls.push_back(c);
      if (!pcs && adc_cs_n) cs_rises.push_back(c);
      if (!psclk && adc_sclk) sclk_rises.push_back(c);
      if (pbusy && !busy) busy_falls.push_back(c);
      pcs   = adc_cs_n;
      psclk = adc_sclk;
      pbusy = busy;
    end
    @(posedge s_clk);
    #1;
    adc_en = 1'b0;
  endtask

  task automatic check_single_timing(input string tag);
    check({tag, "_cs_fall_cnt"}, 32'(cs_falls.size()), 32'd1);
    if (cs_falls.size() > 0) check({tag, "_cs_fall_cyc"}, 32'(cs_falls[0]), 32'd1);
    check({tag, "_cs_rise_cnt"}, 32'(cs_rises.size()), 32'd1);
    if (cs_rises.size() > 0) check({tag, "_cs_rise_cyc"}, 32'(cs_rises[0]), 32'd67);
    check({tag, "_sclk_rise_cnt"}, 32'(sclk_rises.size()), 32'd16);
    if (sclk_rises.size() > 0) begin
      check({tag, "_sclk_first"}, 32'(sclk_rises[0]), 32'd3);
      check({tag, "_sclk_last"}, 32'(sclk_rises[sclk_rises.size()-1]), 32'd63);
    end
    check({tag, "_busy_fall_cnt"}, 32'(busy_falls.size()), 32'd1);
    if (busy_falls.size() > 0) check({tag, "_busy_fall_cyc"}, 32'(busy_falls[0]), 32'd69);
  endtask

  int vld_before;

  initial begin
    // Reset held while adc_en toggles
    for (int i = 0; i < 6; i++) begin
      @(posedge s_clk);
      #1;
      adc_en = (i % 2 == 0);
      @(negedge s_clk);
      check("rst_outputs", {16'h0, adc_cs_n, adc_sclk, adc_vld, busy, adc_data}, 32'h0000_8000);
    end
    adc_en = 1'b0;
    s_rst_n = 1'b1;
    @(posedge s_clk);
    #1;
    check("idle_after_rst", {16'h0, adc_cs_n, adc_sclk, adc_vld, busy, adc_data}, 32'h0000_8000);

    // Single read
    issue_frame(16'h0A5C, 12'hA5C, 67);
    run_window(75, 0, -1, -1, -1);
    check_single_timing("single");
    check("single_data_hold", 32'(adc_data), 32'h0000_0A5C);

    // Leading bits discarded
    issue_frame(16'hFFFF, 12'hFFF, 67);
    run_window(75, 0, -1, -1, -1);
    check("ffff_busy_fall_cnt", 32'(busy_falls.size()), 32'd1);
    issue_frame(16'hF000, 12'h000, 67);
    run_window(75, 0, -1, -1, -1);
    check("f000_busy_fall_cnt", 32'(busy_falls.size()), 32'd1);

    // Busy reject (pulses at 10 and 66) then back-to-back start at 69
    vld_before = vld_cnt;
    issue_frame(16'h0A5C, 12'hA5C, 67);
    issue_frame(16'h0123, 12'h123, 136);
    run_window(145, 0, 10, 66, 69);
    check("b2b_cs_fall_cnt", 32'(cs_falls.size()), 32'd2);
    if (cs_falls.size() > 1) begin
      check("b2b_cs_fall0", 32'(cs_falls[0]), 32'd1);
      check("b2b_cs_fall1", 32'(cs_falls[1]), 32'd70);
    end
    if (cs_rises.size() > 0) check("b2b_cs_rise0", 32'(cs_rises[0]), 32'd67);
    if (busy_falls.size() > 0) check("b2b_busy_fall0", 32'(busy_falls[0]), 32'd69);
    check("b2b_vld_cnt", 32'(vld_cnt - vld_before), 32'd2);

    // Reset mid-frame: partial frame discarded, no result
    frame_q.push_back(16'h5A5A);
    for (int c = 0; c < 30; c++) begin
      @(posedge s_clk);
      #1;
      adc_en = (c == 0);
    end
    @(posedge s_clk);
    #1;
    check("mid_cs_low", 32'(adc_cs_n), 32'd0);
    check("mid_busy", 32'(busy), 32'd1);
    vld_before = vld_cnt;
    s_rst_n = 1'b0;
    #1;
    check("mid_rst_outputs", {16'h0, adc_cs_n, adc_sclk, adc_vld, busy, adc_data}, 32'h0000_8000);
    repeat (3) begin
      @(negedge s_clk);
      check("mid_rst_hold", {16'h0, adc_cs_n, adc_sclk, adc_vld, busy, adc_data}, 32'h0000_8000);
    end
    s_rst_n = 1'b1;
    repeat (80) @(negedge s_clk);
    check("mid_no_vld", 32'(vld_cnt - vld_before), 32'd0);
    check("mid_data_zero", 32'(adc_data), 32'd0);
    check("mid_idle", {31'h0, adc_cs_n}, 32'd1);
    @(posedge s_clk);
    #1;

    // Normal frame after reset release
    issue_frame(16'h5A96, 12'hA96, 67);
    run_window(75, 0, -1, -1, -1);
    check_single_timing("post_rst");

    check("pending_results", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
